bf_ctrl: RTL
============

Name: bf_ctrl

Overview:
- Bloom-filter engine that sits directly upstream of the 32K x 1-bit true dual-port bloom-filter SRAM and is its only driver.
- Accepts query, insert and clear requests keyed by a 64-bit line address.
- Hashes each key to two bit positions and accesses both positions in the same cycle, one per SRAM port.
- Returns a hit/miss response through a valid/ready handshake. One request is in flight at a time.

Parameters:
- ADDR_W, 15, SRAM address width; the filter holds 2^ADDR_W bits.
- KEY_W, 64, request key width.
- RD_LAT, 2, SRAM read latency in cycles, measured from the cycle the address is presented to the cycle q is valid. Legal range 1..3.

Ports:
- clock  in  1  single clock; drives the SRAM too.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid and ready are both high.
- req_op  in  2  00 query, 01 insert, 10 clear, 11 reserved (treated as query).
- req_key  in  KEY_W  key; ignored for clear.
- resp_valid  out  1  response valid; held until resp_ready.
- resp_ready  in  1  response consumed.
- resp_hit  out  1  key present (query/insert); 0 for clear.
- clear_busy  out  1  high while a clear sweep runs.
- sram_address_a  out  ADDR_W  to SRAM address_a.
- sram_address_b  out  ADDR_W  to SRAM address_b.
- sram_data_a  out  1  to SRAM data_a.
- sram_data_b  out  1  to SRAM data_b.
- sram_wren_a  out  1  to SRAM wren_a.
- sram_wren_b  out  1  to SRAM wren_b.
- sram_q_a  in  1  from SRAM q_a.
- sram_q_b  in  1  from SRAM q_b.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low. Asserting reset_n low forces all outputs to 0 immediately, except req_ready, which is 0 during reset and 1 in the first cycle after deassertion.
  - All SRAM-side outputs are registered.
- Hashing, registered at acceptance:
  - f0 = XOR of consecutive ADDR_W-bit chunks of req_key, starting at bit 0. The top chunk is zero-padded; for defaults the chunks are [14:0], [29:15], [44:30], [59:45] and {11'b0,[63:60]}.
  - h0 = f0.
  - h1 = bitreverse(f0) XOR req_key[KEY_W-1 -: ADDR_W].
- FSM states: IDLE, RD, WAIT, WR, CLR, RESP.
  - IDLE: req_ready=1, all wren=0. On acceptance of query/insert go to RD; on acceptance of clear go to CLR.
  - RD (1 cycle): address_a=h0, address_b=h1, wren=0.
  - WAIT: RD_LAT cycles. In the last WAIT cycle, capture hit = sram_q_a & sram_q_b. Query then goes to RESP; insert goes to WR.
  - WR (1 cycle): both addresses held, data=1, wren_a=1, wren_b=1. If h0==h1, wren_b=0 to avoid a same-address dual-port write.
  - CLR: 2^(ADDR_W-1) cycles. In cycle i, address_a=2i, address_b=2i+1, data=0, both wren=1. clear_busy=1 from the first CLR cycle through the last. Then go to RESP with hit=0.
  - RESP: resp_valid=1 and resp_hit stable until resp_ready is sampled high, then return to IDLE. req_ready=0 in every state except IDLE.
- Latency, counted from the acceptance edge:
  - Query: resp_valid rises RD_LAT+2 cycles later.
  - Insert: resp_valid rises RD_LAT+3 cycles later.
  - Clear: resp_valid rises 2^(ADDR_W-1)+1 cycles later.
  - Each additional cycle resp_ready is low extends the response by one cycle.
- Insert response: resp_hit reports presence before the write (1 means duplicate, or a false positive).
- Simultaneous events and hazards:
  - Ops are serialized, so there is no read-after-write hazard.
  - The SRAM is never read and written in the same cycle.
  - A new request presented while resp_valid is high waits; it is accepted in the IDLE cycle after the response handshake.
- Reset during an operation: the FSM returns to IDLE and any partial clear is abandoned. SRAM contents are not reset; software must reissue clear.

Test Plan:
- Reset, then clear; poll every address with a backdoor read -> SRAM all 0. clear_busy is high for exactly 16384 cycles; resp_valid rises 16385 cycles after acceptance with resp_hit=0.
- After clear: query key=1 -> resp_hit=0 at acceptance+4 (RD_LAT=2); SRAM sees address_a=0x0001, address_b=0x4000. Then insert key=1 -> resp_hit=0 at acceptance+5, bits 0x0001 and 0x4000 set. Re-query key=1 -> resp_hit=1.
- False positive: after inserting key=1, query key=0x8000 (hashes to the same 0x0001/0x4000) -> resp_hit=1. Query key=2 (0x0002/0x2000) -> resp_hit=0.
- Collision: insert key=0 (h0=h1=0) -> WR cycle has wren_a=1, wren_b=0, address 0; subsequent query key=0 -> resp_hit=1.
- Backpressure: hold resp_ready=0 for 10 cycles with a second req_valid pending -> resp_valid and resp_hit stable, req_ready=0. The second request is accepted the cycle after IDLE is re-entered.
- Pull reset_n low midway through a clear (cycle 5000) -> all outputs 0 asynchronously, clear_busy=0. After release, req_ready=1; addresses 0..9999 read 0 and address 20000 retains its prior value.

Source files
------------

// File: rtl/bf_ctrl.sv
// Bloom-filter controller: hashes each 64-bit key to two bit positions of a
// true dual-port 1-bit SRAM and performs query, insert and clear sweeps.
module bf_ctrl #(
    parameter int ADDR_W = 15,
    parameter int KEY_W  = 64,
    parameter int RD_LAT = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [KEY_W-1:0]  req_key,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_hit,
    output logic              clear_busy,
    output logic [ADDR_W-1:0] sram_address_a,
    output logic [ADDR_W-1:0] sram_address_b,
    output logic              sram_data_a,
    output logic              sram_data_b,
    output logic              sram_wren_a,
    output logic              sram_wren_b,
    input  logic              sram_q_a,
    input  logic              sram_q_b
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_WR   = 3'd3,
        S_CLR  = 3'd4,
        S_RESP = 3'd5
    } state_t;

    function automatic logic [ADDR_W-1:0] fold_key(input logic [KEY_W-1:0] key);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < KEY_W; i++) begin
            acc[i % ADDR_W] = acc[i % ADDR_W] ^ key[i];
        end
        return acc;
    endfunction

    function automatic logic [ADDR_W-1:0] bit_rev(input logic [ADDR_W-1:0] v);
        logic [ADDR_W-1:0] r;
        r = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            r[i] = v[ADDR_W-1-i];
        end
        return r;
    endfunction

    state_t            state_q;
    logic [ADDR_W-1:0] h0_q, h1_q;
    logic [ADDR_W-1:0] h0_d, h1_d;
    logic              ins_q;
    logic              hit_q;
    logic [1:0]        wait_q;
    logic [ADDR_W-1:0] clr_q;
    logic              rdy_q;
    logic              resp_valid_q;
    logic              resp_hit_q;
    logic              busy_q;
    logic [ADDR_W-1:0] addr_a_q, addr_b_q;
    logic              data_q;
    logic              wren_a_q, wren_b_q;

    assign h0_d = fold_key(req_key);
    assign h1_d = bit_rev(h0_d) ^ req_key[KEY_W-1 -: ADDR_W];

    // rdy_q resets high so the handshake opens in the first cycle after reset release
    assign req_ready      = rdy_q & reset_n;
    assign resp_valid     = resp_valid_q;
    assign resp_hit       = resp_hit_q;
    assign clear_busy     = busy_q;
    assign sram_address_a = addr_a_q;
    assign sram_address_b = addr_b_q;
    assign sram_data_a    = data_q;
    assign sram_data_b    = data_q;
    assign sram_wren_a    = wren_a_q;
    assign sram_wren_b    = wren_b_q;

    // Control FSM; every output register is loaded one cycle ahead of its phase
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            h0_q         <= '0;
            h1_q         <= '0;
            ins_q        <= 1'b0;
            hit_q        <= 1'b0;
            wait_q       <= 2'd0;
            clr_q        <= '0;
            rdy_q        <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            busy_q       <= 1'b0;
            addr_a_q     <= '0;
            addr_b_q     <= '0;
            data_q       <= 1'b0;
            wren_a_q     <= 1'b0;
            wren_b_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && rdy_q) begin
                        rdy_q <= 1'b0;
                        h0_q  <= h0_d;
                        h1_q  <= h1_d;
                        ins_q <= (req_op == 2'b01);
                        clr_q <= '0;
                        if (req_op == 2'b10) begin
                            state_q <= S_CLR;
                        end else begin
                            state_q <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    addr_a_q <= h0_q;
                    addr_b_q <= h1_q;
                    wren_a_q <= 1'b0;
                    wren_b_q <= 1'b0;
                    wait_q   <= 2'd0;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    // read data lands RD_LAT cycles after the address became visible
                    if (wait_q == 2'(RD_LAT)) begin
                        if (ins_q) begin
                            hit_q    <= sram_q_a & sram_q_b;
                            data_q   <= 1'b1;
                            wren_a_q <= 1'b1;
                            wren_b_q <= (h0_q != h1_q);
                            state_q  <= S_WR;
                        end else begin
                            resp_valid_q <= 1'b1;
                            resp_hit_q   <= sram_q_a & sram_q_b;
                            state_q      <= S_RESP;
                        end
                    end else begin
                        wait_q <= wait_q + 2'd1;
                    end
                end
                S_WR: begin
                    data_q       <= 1'b0;
                    wren_a_q     <= 1'b0;
                    wren_b_q     <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_hit_q   <= hit_q;
                    state_q      <= S_RESP;
                end
                S_CLR: begin
                    // MSB of clr_q flags that every address pair has been swept
                    if (clr_q[ADDR_W-1]) begin
                        wren_a_q     <= 1'b0;
                        wren_b_q     <= 1'b0;
                        busy_q       <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_hit_q   <= 1'b0;
                        state_q      <= S_RESP;
                    end else begin
                        addr_a_q <= {clr_q[ADDR_W-2:0], 1'b0};
                        addr_b_q <= {clr_q[ADDR_W-2:0], 1'b1};
                        data_q   <= 1'b0;
                        wren_a_q <= 1'b1;
                        wren_b_q <= 1'b1;
                        busy_q   <= 1'b1;
                        clr_q    <= clr_q + ADDR_W'(1);
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_hit_q   <= 1'b0;
                        rdy_q        <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    rdy_q        <= 1'b1;
                    resp_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    wren_a_q     <= 1'b0;
                    wren_b_q     <= 1'b0;
                end
            endcase
        end
    end

endmodule
